// File: rtl/board_pkg.sv
// Shared constants and FSM state type for the board cell selector.
package board_pkg;

    localparam int N_CELLS    = 9;
    localparam int CELL_W     = 9;
    localparam int CELL_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/board_cell_select_cell_pick.sv
// Combinational cell picker: returns cell[idx], or zero with err set when
// idx does not address a real cell.
module cell_pick
    import board_pkg::*;
#(
    parameter int N_IN   = N_CELLS,
    parameter int DATA_W = CELL_W,
    parameter int SEL_W  = CELL_IDX_W
) (
    input  logic [N_IN*DATA_W-1:0] in_flat_i,
    input  logic [SEL_W-1:0]       idx_i,
    output logic [DATA_W-1:0]      data_o,
    output logic                   err_o
);

    // One-hot compare per cell so out-of-range indices fall through to zero.
    always_comb begin
        data_o = '0;
        err_o  = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_i == SEL_W'(i)) begin
                data_o = in_flat_i[i*DATA_W +: DATA_W];
                err_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/board_cell_select.sv
// Registered board cell selector with direct reads and an auto-scan mode.
// Handshake: a beat/request transfers on a rising edge where valid && ready
// are both high; valid never drops and data never changes until then.
module board_cell_select
    import board_pkg::*;
#(
    parameter int N_IN   = N_CELLS,
    parameter int DATA_W = CELL_W,
    parameter int SEL_W  = CELL_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*DATA_W-1:0] in_flat,
    input  logic                   sel_valid,
    input  logic [SEL_W-1:0]       sel,
    output logic                   sel_ready,
    input  logic                   scan_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_idx,
    output logic                   out_err,
    output logic                   scan_busy,
    output logic                   scan_done,
    output state_t                 dbg_state
);

    localparam logic [SEL_W-1:0] CNT_END = SEL_W'(N_IN);

    state_t              state_q;
    logic [SEL_W-1:0]    cnt_q;
    logic [SEL_W-1:0]    cnt_d;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [SEL_W-1:0]    out_idx_q;
    logic                out_err_q;
    logic                scan_busy_q;
    logic                scan_done_q;

    logic                load_ok;
    logic [SEL_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic                pick_err;

    // The output stage can take a new beat when empty or being drained.
    assign load_ok   = !out_valid_q || out_ready;
    assign sel_ready = (state_q == IDLE) && !scan_start && load_ok;
    assign pick_idx  = (state_q == SCAN) ? cnt_q : sel;
    assign cnt_d     = cnt_q + SEL_W'(1);

    cell_pick #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_pick (
        .in_flat_i (in_flat),
        .idx_i     (pick_idx),
        .data_o    (pick_data),
        .err_o     (pick_err)
    );

    // FSM, scan counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_err_q   <= 1'b0;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        state_q     <= SCAN;
                        cnt_q       <= '0;
                        scan_busy_q <= 1'b1;
                    end else if (sel_valid && sel_ready) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= pick_data;
                        out_idx_q   <= sel;
                        out_err_q   <= pick_err;
                    end
                end
                SCAN: begin
                    if (cnt_q < CNT_END) begin
                        if (load_ok) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= pick_data;
                            out_idx_q   <= cnt_q;
                            out_err_q   <= 1'b0;
                            cnt_q       <= cnt_d;
                        end
                    end else if (out_valid_q && out_ready) begin
                        // Last beat accepted: finish the scan.
                        state_q     <= DONE;
                        scan_busy_q <= 1'b0;
                        scan_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_err   = out_err_q;
    assign scan_busy = scan_busy_q;
    assign scan_done = scan_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_board_cell_select.sv
// Testbench for board_cell_select: directed scenarios plus randomized direct
// traffic checked against a behavioural cell-lookup model and a beat queue.
module tb_board_cell_select;
    import board_pkg::*;

    localparam int N = 9;
    localparam int W = 9;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_flat;
    logic           sel_valid;
    logic [S-1:0]   sel;
    logic           sel_ready;
    logic           scan_start;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_idx;
    logic           out_err;
    logic           scan_busy;
    logic           scan_done;
    state_t         dbg_state;

    logic [W-1:0]   cell_m [N];
    logic [W+S:0]   exp_q [$];
    int             n_cmp = 0;
    int             n_bad = 0;

    // Clock and reset.
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_flat[i*W +: W] = cell_m[i];
    end

    board_cell_select dut (
        .clk        (clk),
        .rst        (rst),
        .in_flat    (in_flat),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .sel_ready  (sel_ready),
        .scan_start (scan_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_err    (out_err),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .dbg_state  (dbg_state)
    );

    // Reference: what a read of index s returns, as {err, idx, data}.
    function automatic logic [W+S:0] ref_pick(input logic [S-1:0] s);
        if (int'(s) < N) return {1'b0, s, cell_m[s]};
        return {1'b1, s, {W{1'b0}}};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cells_incr();
        for (int i = 0; i < N; i++) cell_m[i] = W'(i + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; sel_valid = 1'b0; sel = '0; scan_start = 1'b0; out_ready = 1'b0;
        set_cells_incr();
        cycle(); cycle();
        n_cmp++;
        if ({out_valid, out_data, out_idx, out_err, scan_busy, scan_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b d=%0d i=%0d e=%b busy=%b done=%b, want all 0",
                     out_valid, out_data, out_idx, out_err, scan_busy, scan_done);
        end
        n_cmp++;
        if (sel_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_sel_ready: got %b want 1", sel_ready);
        end
        scan_start = 1'b1; #1;
        n_cmp++;
        if (sel_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_sel_ready_scan: got %b want 0", sel_ready);
        end
        scan_start = 1'b0; rst = 1'b0;
        cycle();
    endtask

    task automatic test_direct();
        int sels [3] = '{0, 4, 8};
        set_cells_incr();
        out_ready = 1'b1; sel_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sel = S'(sels[k]);
            cycle();
            n_cmp++;
            if ({out_valid, out_err, out_idx, out_data} !== {1'b1, 1'b0, S'(sels[k]), W'(sels[k] + 1)}) begin
                n_bad++;
                $display("FAIL direct_%0d: got v=%b e=%b i=%0d d=%0d want v=1 e=0 i=%0d d=%0d",
                         sels[k], out_valid, out_err, out_idx, out_data, sels[k], sels[k] + 1);
            end
        end
        sel_valid = 1'b0;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL direct_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        int sels [2] = '{9, 15};
        out_ready = 1'b1; sel_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sel = S'(sels[k]);
            cycle();
            n_cmp++;
            if ({out_valid, out_err, out_idx, out_data} !== {1'b1, 1'b1, S'(sels[k]), {W{1'b0}}}) begin
                n_bad++;
                $display("FAIL oor_%0d: got v=%b e=%b i=%0d d=%0d want v=1 e=1 i=%0d d=0",
                         sels[k], out_valid, out_err, out_idx, out_data, sels[k]);
            end
        end
        sel_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; sel_valid = 1'b1; sel = 4'd3;
        cycle();
        sel = 4'd5;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({out_valid, out_err, out_idx, out_data, sel_ready} !== {1'b1, 1'b0, 4'd3, 9'd4, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_%0d: got v=%b e=%b i=%0d d=%0d rdy=%b want v=1 e=0 i=3 d=4 rdy=0",
                         k, out_valid, out_err, out_idx, out_data, sel_ready);
            end
            cycle();
        end
        out_ready = 1'b1; #1;
        n_cmp++;
        if (sel_ready !== 1'b1) begin
            n_bad++; $display("FAIL release_ready: got %b want 1", sel_ready);
        end
        cycle();
        n_cmp++;
        if ({out_valid, out_idx, out_data} !== {1'b1, 4'd5, 9'd6}) begin
            n_bad++;
            $display("FAIL release_beat: got v=%b i=%0d d=%0d want v=1 i=5 d=6", out_valid, out_idx, out_data);
        end
        sel_valid = 1'b0;
        cycle();
    endtask

    task automatic test_scan_full();
        set_cells_incr();
        out_ready = 1'b1; sel_valid = 1'b1; sel = 4'd2; scan_start = 1'b1; #1;
        n_cmp++;
        if (sel_ready !== 1'b0) begin
            n_bad++; $display("FAIL scan_priority: sel_ready got %b want 0", sel_ready);
        end
        cycle();
        scan_start = 1'b0;
        n_cmp++;
        if ({scan_busy, out_valid, sel_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL scan_enter: got busy=%b v=%b rdy=%b want busy=1 v=0 rdy=0", scan_busy, out_valid, sel_ready);
        end
        for (int b = 0; b < N; b++) begin
            cycle();
            n_cmp++;
            if ({out_valid, out_err, out_idx, out_data, scan_busy, scan_done, sel_ready}
                !== {1'b1, 1'b0, S'(b), W'(b + 1), 1'b1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL scan_beat_%0d: got v=%b e=%b i=%0d d=%0d busy=%b done=%b rdy=%b want v=1 e=0 i=%0d d=%0d busy=1 done=0 rdy=0",
                         b, out_valid, out_err, out_idx, out_data, scan_busy, scan_done, sel_ready, b, b + 1);
            end
        end
        cycle();
        sel_valid = 1'b0;
        n_cmp++;
        if ({scan_done, out_valid, scan_busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL scan_done_pulse: got done=%b v=%b busy=%b want done=1 v=0 busy=0", scan_done, out_valid, scan_busy);
        end
        cycle();
        n_cmp++;
        if ({scan_done, out_valid} !== 2'b00) begin
            n_bad++; $display("FAIL scan_done_once: got done=%b v=%b want 0 0", scan_done, out_valid);
        end
    endtask

    task automatic test_scan_toggle();
        int done_cnt = 0;
        int cyc = 0;
        logic ph = 1'b1;
        logic [W+S:0] got, want;
        for (int i = 0; i < N; i++) cell_m[i] = W'($urandom);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(ref_pick(S'(i)));
        out_ready = 1'b1; scan_start = 1'b1;
        cycle();
        scan_start = 1'b0;
        while (done_cnt == 0 && cyc < 100) begin
            out_ready = ph; ph = !ph;
            sel_valid = 1'b1; sel = S'($urandom_range(0, 15));
            @(negedge clk);
            if (scan_busy) begin
                n_cmp++;
                if (sel_ready !== 1'b0) begin
                    n_bad++; $display("FAIL toggle_sel_ignored: sel_ready got %b want 0", sel_ready);
                end
            end
            if (out_valid && out_ready) begin
                got = {out_err, out_idx, out_data};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL toggle_extra_beat: got %h, no beat expected", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_bad++; $display("FAIL toggle_beat: got %h want %h", got, want);
                    end
                end
            end
            if (scan_done) done_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        sel_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (scan_done) done_cnt++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL toggle_lost_beats: %0d left want 0", exp_q.size());
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++; $display("FAIL toggle_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_scan_reset();
        int cyc = 0;
        logic stray = 1'b0;
        set_cells_incr();
        out_ready = 1'b1; scan_start = 1'b1;
        cycle();
        scan_start = 1'b0;
        while (!(out_valid && out_idx == 4'd4) && cyc < 20) begin
            cycle(); cyc++;
        end
        n_cmp++;
        if (cyc >= 20) begin
            n_bad++; $display("FAIL rst_scan_reach_beat4: timed out, idx=%0d", out_idx);
        end
        rst = 1'b1;
        cycle();
        n_cmp++;
        if ({out_valid, out_data, out_idx, out_err, scan_busy, scan_done} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_scan: got v=%b d=%0d i=%0d e=%b busy=%b done=%b want all 0",
                     out_valid, out_data, out_idx, out_err, scan_busy, scan_done);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (scan_done || out_valid) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_bad++; $display("FAIL rst_no_done: got stray output after abort, want none");
        end
        scan_start = 1'b1;
        cycle();
        scan_start = 1'b0;
        cycle();
        n_cmp++;
        if ({out_valid, out_idx, out_data} !== {1'b1, 4'd0, 9'd1}) begin
            n_bad++;
            $display("FAIL rst_restart: got v=%b i=%0d d=%0d want v=1 i=0 d=1", out_valid, out_idx, out_data);
        end
        cyc = 0;
        while (!scan_done && cyc < 30) begin
            cycle(); cyc++;
        end
        n_cmp++;
        if (cyc >= 30) begin
            n_bad++; $display("FAIL rst_restart_finish: timed out waiting for scan_done");
        end
        cycle();
    endtask

    task automatic test_random_direct();
        logic         held = 1'b0;
        logic [W+S+1:0] held_v = '0;
        logic [W+S:0] got, want;
        int           j;
        exp_q.delete();
        for (int c = 0; c < 320; c++) begin
            if (c < 300) begin
                sel_valid = 1'($urandom_range(0, 1));
                sel       = S'($urandom_range(0, 15));
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    j = $urandom_range(0, N - 1);
                    cell_m[j] = W'($urandom);
                end
            end else begin
                sel_valid = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            if (held) begin
                n_cmp++;
                if ({out_valid, out_err, out_idx, out_data} !== held_v) begin
                    n_bad++; $display("FAIL rand_hold: got %h want %h", {out_valid, out_err, out_idx, out_data}, held_v);
                end
            end
            held   = out_valid && !out_ready;
            held_v = {out_valid, out_err, out_idx, out_data};
            if (out_valid && out_ready) begin
                got = {out_err, out_idx, out_data};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra_beat: got %h, no beat expected", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_bad++; $display("FAIL rand_beat: got %h want %h", got, want);
                    end
                end
            end
            if (sel_valid && sel_ready) exp_q.push_back(ref_pick(sel));
            @(posedge clk); #1;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL rand_lost_beats: %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_out_of_range();
        test_backpressure();
        test_scan_full();
        test_scan_toggle();
        test_scan_reset();
        test_random_direct();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
